// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column-multiplexed scan, per-frame debounce FSM,
// and a 16-bit nibble entry register for the display data path.
module hex_keypad_scanner #(
  parameter int CNT_WIDTH       = 14,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  i_rows,
  input  logic        i_clear,
  output logic [3:0]  o_cols,
  output logic [3:0]  o_key,
  output logic        o_key_valid,
  output logic        o_pressed,
  output logic [15:0] o_data
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  localparam logic [3:0]           DF       = 4'(DEBOUNCE_FRAMES);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_r, cnt_next_s;
  logic [1:0]           col_s, col_next_s;
  logic [3:0]           cols_r;
  logic [3:0]           rows_meta_r, rows_sync_r, rows_s;
  logic [15:0]          map_r;
  logic                 capture_s, eval_s;
  logic                 found_s, multi_s, single_s;
  logic [3:0]           idx_s;
  state_t               state_r, state_n;
  logic [3:0]           cand_r, cand_n, count_r, count_n, rcount_r, rcount_n;
  logic                 accept_s;
  logic [3:0]           key_r;
  logic                 key_valid_r;
  logic [15:0]          data_r;

  assign cnt_next_s = cnt_r + CNT_ONE;
  assign col_s      = cnt_r[CNT_WIDTH-1:CNT_WIDTH-2];
  assign col_next_s = cnt_next_s[CNT_WIDTH-1:CNT_WIDTH-2];
  assign capture_s  = &cnt_r[CNT_WIDTH-3:0];
  assign eval_s     = (cnt_r == CNT_ZERO);
  assign rows_s     = rows_sync_r;

  // Scan counter; column drive is decoded from the next count so it leaves a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= CNT_ZERO;
      cols_r <= 4'b1110;
    end else begin
      cnt_r  <= cnt_next_s;
      cols_r <= ~(4'b0001 << col_next_s);
    end
  end

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_meta_r <= 4'b1111;
      rows_sync_r <= 4'b1111;
    end else begin
      rows_meta_r <= i_rows;
      rows_sync_r <= rows_meta_r;
    end
  end

  // Key map: sample the active column on the last cycle of its dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_r <= 16'h0000;
    end else if (capture_s) begin
      map_r[{2'd0, col_s}] <= ~rows_s[0];
      map_r[{2'd1, col_s}] <= ~rows_s[1];
      map_r[{2'd2, col_s}] <= ~rows_s[2];
      map_r[{2'd3, col_s}] <= ~rows_s[3];
    end else begin
      map_r <= map_r;
    end
  end

  // Classify the frame map as none / single(idx) / multi.
  always_comb begin
    found_s = 1'b0;
    multi_s = 1'b0;
    idx_s   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      multi_s = multi_s | (found_s & map_r[i]);
      idx_s   = (map_r[i] && !found_s) ? 4'(i) : idx_s;
      found_s = found_s | map_r[i];
    end
    single_s = found_s & ~multi_s;
  end

  // Debounce FSM next-state; only advances on the frame evaluation cycle.
  always_comb begin
    state_n  = state_r;
    cand_n   = cand_r;
    count_n  = count_r;
    rcount_n = rcount_r;
    accept_s = 1'b0;
    if (eval_s) begin
      case (state_r)
        ST_IDLE: begin
          if (single_s) begin
            cand_n  = idx_s;
            count_n = 4'd1;
            if (DF == 4'd1) begin
              accept_s = 1'b1;
              rcount_n = 4'd0;
              state_n  = ST_HELD;
            end else begin
              state_n  = ST_DEBOUNCE;
            end
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_DEBOUNCE: begin
          if (!single_s) begin
            state_n = ST_IDLE;
          end else if (idx_s != cand_r) begin
            cand_n  = idx_s;
            count_n = 4'd1;
          end else begin
            count_n = count_r + 4'd1;
            if (count_n == DF) begin
              accept_s = 1'b1;
              rcount_n = 4'd0;
              state_n  = ST_HELD;
            end else begin
              state_n  = ST_DEBOUNCE;
            end
          end
        end
        ST_HELD: begin
          if (found_s) begin
            rcount_n = 4'd0;
          end else begin
            rcount_n = rcount_r + 4'd1;
            if (rcount_n == DF) begin
              rcount_n = 4'd0;
              state_n  = ST_IDLE;
            end else begin
              state_n  = ST_HELD;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cand_r   <= 4'd0;
      count_r  <= 4'd0;
      rcount_r <= 4'd0;
    end else begin
      state_r  <= state_n;
      cand_r   <= cand_n;
      count_r  <= count_n;
      rcount_r <= rcount_n;
    end
  end

  // Accept outputs; a clear on the accept edge drops the new nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r       <= 4'd0;
      key_valid_r <= 1'b0;
      data_r      <= 16'h0000;
    end else begin
      key_valid_r <= accept_s;
      key_r       <= accept_s ? cand_n : key_r;
      if (i_clear) begin
        data_r <= 16'h0000;
      end else if (accept_s) begin
        data_r <= {data_r[11:0], cand_n};
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign o_cols      = cols_r;
  assign o_key       = key_r;
  assign o_key_valid = key_valid_r;
  assign o_pressed   = (state_r == ST_HELD);
  assign o_data      = data_r;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Self-checking bench for hex_keypad_scanner: a frame-level keypad model drives
// the rows from the column drive, and a run-length debounce model predicts outputs.
module tb_hex_keypad_scanner;

  localparam int CW = 4;
  localparam int DF = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_rows;
  logic        i_clear;
  logic [3:0]  o_cols;
  logic [3:0]  o_key;
  logic        o_key_valid;
  logic        o_pressed;
  logic [15:0] o_data;

  hex_keypad_scanner #(.CNT_WIDTH(CW), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk), .rst_n(rst_n), .i_rows(i_rows), .i_clear(i_clear),
    .o_cols(o_cols), .o_key(o_key), .o_key_valid(o_key_valid),
    .o_pressed(o_pressed), .o_data(o_data)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          pulses = 0;
  logic [15:0] pressed_set = 16'h0000;

  // Keypad matrix: a row reads low if any pressed key sits in a driven-low column.
  always_comb begin
    i_rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed_set[4*r+c] && !o_cols[c]) i_rows[r] = 1'b0;
  end

  // Reference model state (frame level)
  bit          m_held;
  int          m_run_key, m_run_len, m_empty_run;
  logic [3:0]  m_key;
  logic [15:0] m_data;

  task automatic model_reset();
    m_held = 0; m_run_key = 0; m_run_len = 0; m_empty_run = 0;
    m_key = 4'd0; m_data = 16'h0000;
  endtask

  task automatic model_frame(input logic [15:0] keys, input bit clr, output bit acc);
    int n, k;
    n = $countones(keys);
    k = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) k = i;
    acc = 0;
    if (!m_held) begin
      if (n == 1) begin
        m_run_len = (m_run_len > 0 && k == m_run_key) ? m_run_len + 1 : 1;
        m_run_key = k;
        if (m_run_len >= DF) begin
          acc = 1; m_held = 1; m_empty_run = 0; m_run_len = 0;
        end
      end else m_run_len = 0;
    end else begin
      if (n == 0) begin
        m_empty_run++;
        if (m_empty_run >= DF) m_held = 0;
      end else m_empty_run = 0;
    end
    if (acc) m_key = 4'(k);
    if (clr) m_data = 16'h0000;
    else if (acc) m_data = {m_data[11:0], 4'(k)};
  endtask

  // One full scan frame with the given key set; starts just after an evaluation edge.
  task automatic run_frame(input logic [15:0] keys, input bit clr);
    bit acc;
    logic [3:0] exp_cols;
    acc = 0;
    pressed_set = keys;
    for (int j = 1; j <= 16; j++) begin
      i_clear = (j == 16) ? clr : 1'b0;
      @(posedge clk);
      if (j == 16) model_frame(keys, clr, acc);
      @(negedge clk);
      exp_cols = ~(4'b0001 << (((1 + j) % 16) / 4));
      if (o_key_valid) pulses++;
      n_cmp += 5;
      if (o_cols !== exp_cols) begin n_err++; $display("FAIL cols j=%0d: got %b want %b", j, o_cols, exp_cols); end
      if (o_key_valid !== ((j == 16) && acc)) begin n_err++; $display("FAIL key_valid j=%0d: got %b want %b", j, o_key_valid, (j == 16) && acc); end
      if (o_pressed !== m_held) begin n_err++; $display("FAIL pressed j=%0d: got %b want %b", j, o_pressed, m_held); end
      if (o_key !== m_key) begin n_err++; $display("FAIL key j=%0d: got %h want %h", j, o_key, m_key); end
      if (o_data !== m_data) begin n_err++; $display("FAIL data j=%0d: got %h want %h", j, o_data, m_data); end
    end
    i_clear = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    n_cmp += 5;
    if (o_cols !== 4'b1110) begin n_err++; $display("FAIL %s cols: got %b want 1110", tag, o_cols); end
    if (o_key !== 4'd0) begin n_err++; $display("FAIL %s key: got %h want 0", tag, o_key); end
    if (o_key_valid !== 1'b0) begin n_err++; $display("FAIL %s key_valid: got %b want 0", tag, o_key_valid); end
    if (o_pressed !== 1'b0) begin n_err++; $display("FAIL %s pressed: got %b want 0", tag, o_pressed); end
    if (o_data !== 16'h0000) begin n_err++; $display("FAIL %s data: got %h want 0", tag, o_data); end
  endtask

  task automatic check_pulses(input string tag, input int want);
    n_cmp++;
    if (pulses != want) begin n_err++; $display("FAIL %s pulses: got %0d want %0d", tag, pulses, want); end
  endtask

  task automatic check_data(input string tag, input logic [15:0] want);
    n_cmp++;
    if (o_data !== want) begin n_err++; $display("FAIL %s data: got %h want %h", tag, o_data, want); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_clear = 1'b0; pressed_set = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check_zero_outputs("after_release");
    pulses = 0;
    for (int f = 0; f < 10; f++) run_frame(16'h0000, 1'b0);
    check_pulses("idle", 0);
  endtask

  task automatic test_single_hold();
    pulses = 0;
    for (int f = 0; f < 5; f++) run_frame(16'h0040, 1'b0);
    check_pulses("hold6", 1);
    check_data("hold6", 16'h0006);
    for (int f = 0; f < 3; f++) run_frame(16'h0000, 1'b0);
  endtask

  task automatic test_sequence();
    logic [15:0] seq [4] = '{16'h0002, 16'h0004, 16'h0008, 16'h0010};
    pulses = 0;
    for (int s = 0; s < 4; s++) begin
      for (int f = 0; f < 3; f++) run_frame(seq[s], 1'b0);
      for (int f = 0; f < 3; f++) run_frame(16'h0000, 1'b0);
    end
    check_pulses("seq1234", 4);
    check_data("seq1234", 16'h1234);
  endtask

  task automatic test_bounce();
    pulses = 0;
    for (int f = 0; f < 8; f++) run_frame((f % 2 == 0) ? 16'h0200 : 16'h0000, 1'b0);
    check_pulses("bounce", 0);
  endtask

  task automatic test_multi_and_clear();
    pulses = 0;
    for (int f = 0; f < 4; f++) run_frame(16'h0801, 1'b0);
    check_pulses("multi", 0);
    run_frame(16'h0800, 1'b0);
    run_frame(16'h0800, 1'b1);
    n_cmp += 2;
    if (o_key !== 4'hB) begin n_err++; $display("FAIL clear_accept key: got %h want b", o_key); end
    if (o_data !== 16'h0000) begin n_err++; $display("FAIL clear_accept data: got %h want 0", o_data); end
    check_pulses("clear_accept", 1);
    for (int f = 0; f < 3; f++) run_frame(16'h0000, 1'b0);
  endtask

  task automatic test_reset_mid_held();
    for (int f = 0; f < 3; f++) run_frame(16'h0020, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    pulses = 0;
    for (int f = 0; f < 2; f++) run_frame(16'h0020, 1'b0);
    check_pulses("reaccept5", 1);
    check_data("reaccept5", 16'h0005);
    for (int f = 0; f < 3; f++) run_frame(16'h0000, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] cur, k2;
    cur = 16'h0000;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) >= 6) begin
        case ($urandom_range(0, 2))
          0: cur = 16'h0000;
          1: cur = 16'h0001 << $urandom_range(0, 15);
          default: begin
            cur = 16'h0001 << $urandom_range(0, 15);
            k2  = 16'h0001 << $urandom_range(0, 15);
            cur = cur | k2;
          end
        endcase
      end
      run_frame(cur, $urandom_range(0, 9) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_sequence();
    test_bounce();
    test_multi_and_clear();
    test_reset_mid_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
